// File: rtl/ep2_axis_pkg.sv
// Shared AXI-stream beat type and arbiter FSM encoding for the ep2 egress paths.
package ep2_axis_pkg;

    localparam int unsigned AXIS_DATA_W = 512;
    localparam int unsigned AXIS_KEEP_W = AXIS_DATA_W / 8;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] data;
        logic [AXIS_KEEP_W-1:0] keep;
        logic                   last;
    } axis_beat_t;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    typedef enum logic [0:0] {
        IDLE   = ST_IDLE,
        LOCKED = ST_LOCKED
    } arb_state_e;

endpackage

// File: rtl/net_send_arbiter_if.sv
// Valid/ready beat stream carrying a packed beat of W bits.
interface net_send_arbiter_if #(
    parameter int unsigned W = $bits(ep2_axis_pkg::axis_beat_t)
) ();
    logic [W-1:0] beat;
    logic         valid;
    logic         ready;

    modport master (output beat, output valid, input ready);
    modport slave  (input beat, input valid, output ready);
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry skid stage: registered ready (not full) and registered output valid,
// output beat held stable while stalled.
module axis_skid_buffer #(
    parameter type beat_t = ep2_axis_pkg::axis_beat_t
) (
    input  logic                      clk,
    input  logic                      rst_n,
    net_send_arbiter_if.slave         up,
    net_send_arbiter_if.master        dn
);

    beat_t      main_q, main_d;
    beat_t      spare_q, spare_d;
    logic [1:0] cnt_q, cnt_d;
    logic       ready_q;
    logic       valid_q;
    logic       push;
    logic       pop;

    assign push = up.valid & ready_q;
    assign pop  = valid_q & dn.ready;

    // main_q is always the head; spare_q only holds the second entry when full.
    always_comb begin
        main_d  = main_q;
        spare_d = spare_q;
        cnt_d   = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    main_d = up.beat;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    main_d = up.beat;
                end else if (push) begin
                    spare_d = up.beat;
                    cnt_d   = 2'd2;
                end else if (pop) begin
                    cnt_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    main_d = spare_q;
                    cnt_d  = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q  <= '0;
            spare_q <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            main_q  <= main_d;
            spare_q <= spare_d;
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d != 2'd2);
            valid_q <= (cnt_d != 2'd0);
        end
    end

    assign up.ready = ready_q;
    assign dn.valid = valid_q;
    assign dn.beat  = main_q;

endmodule

// File: rtl/net_send_arbiter.sv
// Packet-locked round-robin merge of NUM_IN egress streams onto one MAC port,
// with a two-entry skid stage and per-input forwarded-packet counters.
module net_send_arbiter
    import ep2_axis_pkg::*;
#(
    parameter int unsigned NUM_IN = 2,
    parameter int unsigned DATA_W = AXIS_DATA_W,
    parameter int unsigned KEEP_W = DATA_W / 8,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*DATA_W-1:0] in_tdata,
    input  logic [NUM_IN*KEEP_W-1:0] in_tkeep,
    input  logic [NUM_IN-1:0]        in_tlast,
    input  logic [NUM_IN-1:0]        in_tvalid,
    output logic [NUM_IN-1:0]        in_tready,
    output logic [DATA_W-1:0]        out_tdata,
    output logic [KEEP_W-1:0]        out_tkeep,
    output logic                     out_tlast,
    output logic                     out_tvalid,
    input  logic                     out_tready,
    output logic [NUM_IN*CNT_W-1:0]  pkt_cnt,
    output logic                     busy
);

    localparam int unsigned GW = $clog2(NUM_IN);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    arb_state_e                     state_q, state_d;
    logic [GW-1:0]                  grant_q, grant_d;
    logic [GW-1:0]                  last_q, last_d;
    logic [NUM_IN-1:0][CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [NUM_IN-1:0][DATA_W-1:0]  in_data_v;
    logic [NUM_IN-1:0][KEEP_W-1:0]  in_keep_v;
    logic                           accept;
    beat_t                          in_beat;
    beat_t                          out_beat;

    net_send_arbiter_if #(.W($bits(beat_t))) skid_in  ();
    net_send_arbiter_if #(.W($bits(beat_t))) skid_out ();

    function automatic logic [GW-1:0] rr_pick(input logic [NUM_IN-1:0] req,
                                              input logic [GW-1:0]     last);
        logic [GW-1:0] cand;
        logic          found;
        rr_pick = last;
        found   = 1'b0;
        for (int unsigned k = 1; k <= NUM_IN; k++) begin
            cand = GW'((32'(last) + k) % NUM_IN);
            if (!found && req[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    endfunction

    assign in_data_v = in_tdata;
    assign in_keep_v = in_tkeep;

    assign in_beat.data = in_data_v[grant_q];
    assign in_beat.keep = in_keep_v[grant_q];
    assign in_beat.last = in_tlast[grant_q];

    assign skid_in.beat  = in_beat;
    assign skid_in.valid = (state_q == LOCKED) && in_tvalid[grant_q];
    assign accept        = skid_in.valid && skid_in.ready;

    assign in_tready = (state_q == LOCKED) ? (NUM_IN'(skid_in.ready) << grant_q) : '0;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        pkt_cnt_d = pkt_cnt_q;
        case (state_q)
            IDLE: begin
                if (|in_tvalid) begin
                    grant_d = rr_pick(in_tvalid, last_q);
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (accept && in_tlast[grant_q]) begin
                    last_d             = grant_q;
                    pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + CNT_W'(1);
                    state_d            = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= GW'(NUM_IN - 1);
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    axis_skid_buffer #(.beat_t(beat_t)) u_skid (
        .clk   (clk),
        .rst_n (rst),
        .up    (skid_in),
        .dn    (skid_out)
    );

    assign out_beat       = skid_out.beat;
    assign skid_out.ready = out_tready;
    assign out_tdata      = out_beat.data;
    assign out_tkeep      = out_beat.keep;
    assign out_tlast      = out_beat.last;
    assign out_tvalid     = skid_out.valid;

    assign pkt_cnt = pkt_cnt_q;
    assign busy    = (state_q == LOCKED) || skid_out.valid;

endmodule

// File: tb/tb_net_send_arbiter.sv
// Directed bench for net_send_arbiter: cycle table plus hand-written corner sequences.
module tb_net_send_arbiter;

    localparam int unsigned NI = 2;
    localparam int unsigned DW = 512;
    localparam int unsigned KW = 64;
    localparam int unsigned CW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NI*DW-1:0]  in_tdata = '0;
    logic [NI*KW-1:0]  in_tkeep = '0;
    logic [NI-1:0]     in_tlast = '0;
    logic [NI-1:0]     in_tvalid = '0;
    logic [NI-1:0]     in_tready;
    logic [DW-1:0]     out_tdata;
    logic [KW-1:0]     out_tkeep;
    logic              out_tlast;
    logic              out_tvalid;
    logic              out_tready = 1'b1;
    logic [NI*CW-1:0]  pkt_cnt;
    logic              busy;

    int checks = 0;
    int errors = 0;
    logic [9:0] rxq[$];

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  l;
        logic [7:0]  t0;
        logic [7:0]  t1;
        logic [1:0]  e_rdy;
        logic        e_ov;
        logic        e_ol;
        logic [7:0]  e_tag;
        logic        e_busy;
        logic [63:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    net_send_arbiter_if #(.W(DW + KW + 1)) mon_if ();
    assign mon_if.beat  = {out_tdata, out_tkeep, out_tlast};
    assign mon_if.valid = out_tvalid;
    assign mon_if.ready = out_tready;

    net_send_arbiter #(
        .NUM_IN (NI),
        .DATA_W (DW),
        .KEEP_W (KW),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_tdata   (in_tdata),
        .in_tkeep   (in_tkeep),
        .in_tlast   (in_tlast),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_tkeep  (out_tkeep),
        .out_tlast  (out_tlast),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .pkt_cnt    (pkt_cnt),
        .busy       (busy)
    );

    function automatic logic [DW-1:0] mk_data(input logic [7:0] t);
        logic [DW-1:0] d;
        d          = '0;
        d[7:0]     = t;
        d[263:256] = ~t;
        d[511:504] = t ^ 8'h5A;
        return d;
    endfunction

    function automatic logic [KW-1:0] mk_keep(input logic [7:0] t);
        logic [KW-1:0] k;
        k      = '1;
        k[7:0] = t;
        return k;
    endfunction

    function automatic vec_t mkv(input logic [1:0] v, input logic [1:0] l,
                                 input logic [7:0] t0, input logic [7:0] t1,
                                 input logic [1:0] rdy, input logic ov, input logic ol,
                                 input logic [7:0] tag, input logic bsy,
                                 input logic [31:0] c1, input logic [31:0] c0);
        vec_t r;
        r.v = v; r.l = l; r.t0 = t0; r.t1 = t1;
        r.e_rdy = rdy; r.e_ov = ov; r.e_ol = ol; r.e_tag = tag; r.e_busy = bsy;
        r.e_cnt = {c1, c0};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_rdy(input int src);
        int n;
        n = 0;
        while (!in_tready[src] && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("in%0d_ready_seen", src), 512'(in_tready[src]), 512'(1));
    endtask

    // Called at a negedge; returns at the negedge after the last beat is accepted.
    task automatic send(input int src, input int n, input logic [7:0] t0);
        for (int b = 0; b < n; b++) begin
            in_tvalid[src]            = 1'b1;
            in_tlast[src]             = (b == n - 1);
            in_tdata[src*DW +: DW]    = mk_data(8'(t0 + b));
            in_tkeep[src*KW +: KW]    = mk_keep(8'(t0 + b));
            wait_rdy(src);
            @(negedge clk);
        end
        in_tvalid[src] = 1'b0;
        in_tlast[src]  = 1'b0;
    endtask

    task automatic cmp_q(input string nm, input logic [9:0] exp[$]);
        chk({nm, "_len"}, 512'(rxq.size()), 512'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < rxq.size())
                chk($sformatf("%s_beat%0d", nm, i), 512'(rxq[i]), 512'(exp[i]));
        end
    endtask

    // Records {data_ok, tlast, tag} for every beat that completes at the next posedge.
    initial begin
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [7:0]    t;
        forever begin
            @(negedge clk);
            #2;
            if (rst && mon_if.valid && mon_if.ready) begin
                d = mon_if.beat[DW+KW:KW+1];
                k = mon_if.beat[KW:1];
                t = d[7:0];
                rxq.push_back({(d == mk_data(t)) && (k == mk_keep(t)), mon_if.beat[0], t});
            end
        end
    end

    initial begin
        logic [9:0] eq[$];
        logic [5:0] pat;
        logic       stall;
        logic [DW-1:0] prev_d;
        logic       prev_l;
        int         n;

        // contention round, then in0 re-offered alone
        vecs.push_back(mkv(2'b11, 2'b00, 8'h01, 8'h11, 2'b00, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mkv(2'b11, 2'b00, 8'h01, 8'h11, 2'b01, 0, 0, 8'h00, 1, 0, 0));
        vecs.push_back(mkv(2'b11, 2'b01, 8'h02, 8'h11, 2'b01, 1, 0, 8'h01, 1, 0, 0));
        vecs.push_back(mkv(2'b10, 2'b00, 8'h02, 8'h11, 2'b00, 1, 1, 8'h02, 1, 0, 1));
        vecs.push_back(mkv(2'b10, 2'b00, 8'h00, 8'h11, 2'b10, 0, 0, 8'h00, 1, 0, 1));
        vecs.push_back(mkv(2'b10, 2'b10, 8'h00, 8'h12, 2'b10, 1, 0, 8'h11, 1, 0, 1));
        vecs.push_back(mkv(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1, 1, 8'h12, 1, 1, 1));
        vecs.push_back(mkv(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 0, 1, 1));
        vecs.push_back(mkv(2'b01, 2'b00, 8'h03, 8'h00, 2'b00, 0, 0, 8'h00, 0, 1, 1));
        vecs.push_back(mkv(2'b01, 2'b00, 8'h03, 8'h00, 2'b01, 0, 0, 8'h00, 1, 1, 1));
        vecs.push_back(mkv(2'b01, 2'b00, 8'h04, 8'h00, 2'b01, 1, 0, 8'h03, 1, 1, 1));
        vecs.push_back(mkv(2'b01, 2'b01, 8'h05, 8'h00, 2'b01, 1, 0, 8'h04, 1, 1, 1));
        vecs.push_back(mkv(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1, 1, 8'h05, 1, 1, 2));
        vecs.push_back(mkv(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 0, 1, 2));

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_tready", 512'(in_tready), 512'(0));
        chk("rst_out_tvalid", 512'(out_tvalid), 512'(0));
        chk("rst_out_tdata", out_tdata, 512'(0));
        chk("rst_out_tkeep", 512'(out_tkeep), 512'(0));
        chk("rst_out_tlast", 512'(out_tlast), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_pkt_cnt", 512'(pkt_cnt), 512'(0));
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            in_tvalid  = vecs[i].v;
            in_tlast   = vecs[i].l;
            in_tdata   = {mk_data(vecs[i].t1), mk_data(vecs[i].t0)};
            in_tkeep   = {mk_keep(vecs[i].t1), mk_keep(vecs[i].t0)};
            out_tready = 1'b1;
            #1;
            chk($sformatf("r%0d_in_tready", i), 512'(in_tready), 512'(vecs[i].e_rdy));
            chk($sformatf("r%0d_out_tvalid", i), 512'(out_tvalid), 512'(vecs[i].e_ov));
            chk($sformatf("r%0d_busy", i), 512'(busy), 512'(vecs[i].e_busy));
            chk($sformatf("r%0d_pkt_cnt", i), 512'(pkt_cnt), 512'(vecs[i].e_cnt));
            if (vecs[i].e_ov) begin
                chk($sformatf("r%0d_out_tlast", i), 512'(out_tlast), 512'(vecs[i].e_ol));
                chk($sformatf("r%0d_out_tdata", i), out_tdata, mk_data(vecs[i].e_tag));
                chk($sformatf("r%0d_out_tkeep", i), 512'(out_tkeep), 512'(mk_keep(vecs[i].e_tag)));
            end
        end

        // no interleave: in0 stalls mid-packet while in1 waits
        @(negedge clk);
        in_tvalid = '0;
        in_tlast  = '0;
        rxq.delete();
        in_tvalid[0]       = 1'b1;
        in_tdata[0 +: DW]  = mk_data(8'h06);
        in_tkeep[0 +: KW]  = mk_keep(8'h06);
        fork
            begin
                wait_rdy(0);
                @(negedge clk);
                in_tvalid[0] = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    chk($sformatf("hold%0d_in_tready", c), 512'(in_tready), 512'(2'b01));
                end
                in_tvalid[0]      = 1'b1;
                in_tlast[0]       = 1'b1;
                in_tdata[0 +: DW] = mk_data(8'h07);
                in_tkeep[0 +: KW] = mk_keep(8'h07);
                wait_rdy(0);
                @(negedge clk);
                in_tvalid[0] = 1'b0;
                in_tlast[0]  = 1'b0;
            end
            begin
                @(negedge clk);
                send(1, 1, 8'h13);
            end
        join
        repeat (4) @(negedge clk);
        eq = {10'h206, 10'h307, 10'h313};
        cmp_q("nointlv", eq);
        chk("nointlv_pkt_cnt", 512'(pkt_cnt), 512'({32'd2, 32'd3}));

        // backpressure during an 8-beat packet
        rxq.delete();
        pat = 6'b101001;
        stall = 1'b0;
        prev_d = '0;
        prev_l = 1'b0;
        fork
            send(0, 8, 8'h50);
            begin
                n = 0;
                while (!out_tvalid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_first_valid", 512'(out_tvalid), 512'(1));
                for (int k = 0; k < 6; k++) begin
                    if (stall) begin
                        chk($sformatf("bp%0d_hold_valid", k), 512'(out_tvalid), 512'(1));
                        chk($sformatf("bp%0d_hold_data", k), out_tdata, prev_d);
                        chk($sformatf("bp%0d_hold_last", k), 512'(out_tlast), 512'(prev_l));
                    end
                    out_tready = pat[k];
                    prev_d     = out_tdata;
                    prev_l     = out_tlast;
                    stall      = out_tvalid && !pat[k];
                    @(negedge clk);
                end
                out_tready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        eq.delete();
        for (int k = 0; k < 8; k++) eq.push_back({1'b1, k == 7, 8'(8'h50 + k)});
        cmp_q("bp", eq);
        chk("bp_pkt_cnt", 512'(pkt_cnt), 512'({32'd2, 32'd4}));

        // counter wrap on input 1
        @(negedge clk);
        force dut.pkt_cnt_q = {32'hFFFF_FFFF, 32'd4};
        @(negedge clk);
        release dut.pkt_cnt_q;
        #1;
        chk("wrap_preload", 512'(pkt_cnt), 512'({32'hFFFF_FFFF, 32'd4}));
        @(negedge clk);
        send(1, 1, 8'h60);
        repeat (3) @(negedge clk);
        chk("wrap_pkt_cnt", 512'(pkt_cnt), 512'({32'd0, 32'd4}));

        // reset during beat 2 of a 4-beat packet
        in_tvalid[0]      = 1'b1;
        in_tlast[0]       = 1'b0;
        in_tdata[0 +: DW] = mk_data(8'h70);
        in_tkeep[0 +: KW] = mk_keep(8'h70);
        wait_rdy(0);
        @(negedge clk);
        in_tdata[0 +: DW] = mk_data(8'h71);
        in_tkeep[0 +: KW] = mk_keep(8'h71);
        #1;
        chk("prerst_out_tvalid", 512'(out_tvalid), 512'(1));
        rst = 1'b0;
        #1;
        chk("midrst_out_tvalid", 512'(out_tvalid), 512'(0));
        chk("midrst_in_tready", 512'(in_tready), 512'(0));
        chk("midrst_busy", 512'(busy), 512'(0));
        chk("midrst_pkt_cnt", 512'(pkt_cnt), 512'(0));
        @(negedge clk);
        rst                = 1'b1;
        in_tvalid          = 2'b11;
        in_tlast           = 2'b10;
        in_tdata[DW +: DW] = mk_data(8'h80);
        in_tkeep[KW +: KW] = mk_keep(8'h80);
        #1;
        chk("postrst_idle_in_tready", 512'(in_tready), 512'(2'b00));
        @(negedge clk);
        #1;
        chk("postrst_grant_in_tready", 512'(in_tready), 512'(2'b01));
        in_tlast[0] = 1'b1;
        @(negedge clk);
        in_tvalid[0] = 1'b0;
        in_tlast[0]  = 1'b0;
        wait_rdy(1);
        @(negedge clk);
        in_tvalid = '0;
        in_tlast  = '0;
        repeat (4) @(negedge clk);
        chk("postrst_pkt_cnt", 512'(pkt_cnt), 512'({32'd1, 32'd1}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
